uc_bcast_arb: RTL
=================

// Module: uc_bcast_arb
// PURPOSE
//  Unit-clause arbiter between NUM_PROC BCP processors. Drains each processor's implication queue (UCQ_in) round-robin.
//  Checks every implied literal against a global variable-assignment table: new literals are recorded, duplicates are dropped.
//  New literals are broadcast to every processor's UCQ_out in the same cycle; a literal contradicting a recorded one raises conflict.
// PARAMETERS
//  NUM_PROC  4    number of proc instances served
//  LIT_W     16   literal width; signed two's complement, var index = |lit|, sign = polarity
//  NUM_VARS  255  highest legal variable index; index 0 is illegal
//  CNT_W     16   width of broadcast counter
// PORTS
//  clk            in   1               clock
//  rst_n          in   1               synchronous active-low reset
//  clear          in   1               synchronous restart: wipe table, conflict, bad_lit, counter
//  ucq_in_empty   in   NUM_PROC        per-proc UCQ_in empty
//  ucq_in_lit     in   NUM_PROC*LIT_W  per-proc UCQ_in head; proc i at [i*LIT_W +: LIT_W]
//  ucq_in_pop     out  NUM_PROC        one-hot pop to the granted UCQ_in
//  ucq_out_full   in   NUM_PROC        per-proc UCQ_out full
//  ucq_out_push   out  1               broadcast push to all UCQ_out
//  ucq_out_lit    out  LIT_W           broadcast literal, valid with push
//  conflict       out  1               sticky: contradicting literal implied
//  conflict_lit   out  LIT_W           the rejected literal, held while conflict=1
//  bad_lit        out  1               sticky: literal with index 0 or >NUM_VARS seen
//  quiescent      out  1               state SCAN and all ucq_in_empty=1
//  bcast_cnt      out  CNT_W           number of literals broadcast, saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge)
//   - state=SCAN, rr_ptr=0, table all unassigned.
//   - All outputs 0, except quiescent, which follows its definition.
//   - Reset mid-operation abandons any latched candidate; that literal is lost.
//  FSM: SCAN -> CHECK -> (BCAST | SCAN | HALT)
//  SCAN
//   - Grant the first proc i with ucq_in_empty[i]=0, searching rr_ptr, rr_ptr+1, ... mod NUM_PROC.
//   - Assert ucq_in_pop[i] for exactly that cycle and latch cand=ucq_in_lit[i].
//   - Set rr_ptr=(i+1) mod NUM_PROC, then go to CHECK.
//   - If no proc is non-empty: stay in SCAN with no pop.
//  CHECK: read table[|cand|] = {assigned, value}.
//   - Index 0 or >NUM_VARS: set bad_lit, drop, go to SCAN.
//   - Unassigned: write assigned=1, value=(cand>0), go to BCAST.
//   - Assigned, same polarity: duplicate; drop silently, go to SCAN.
//   - Assigned, opposite polarity: conflict=1, conflict_lit=cand, go to HALT.
//  BCAST
//   - Wait while any ucq_out_full=1.
//   - Otherwise push=1 for exactly 1 cycle with ucq_out_lit=cand.
//   - bcast_cnt+=1, saturating at all-ones; go to SCAN.
//   - The broadcast reaches all procs in the same cycle, including the originator.
//  HALT: no pops, no pushes; remain until clear or reset.
//  clear
//   - Has priority over every FSM action in that cycle.
//   - Next state: SCAN, table empty, sticky flags 0, counter 0; rr_ptr kept.
//   - clear and rst_n=0 in the same cycle: reset wins (identical result, rr_ptr=0).
//  Latency and throughput
//   - Pop in cycle t, push in cycle t+2 at the earliest.
//   - At most 1 literal per 3 cycles.
//  Outputs: ucq_out_lit is 0 when push=0, and conflict_lit is 0 when conflict=0.
//  Table write in CHECK is visible to the next CHECK, so no same-literal race between procs.
//  Never pops while in CHECK, BCAST or HALT; at most one pop per cycle.
//  Never pushes when any ucq_out_full=1.
// TESTING
//  1. Reset, proc0 head=+5 -> pop[0] @t, push @t+2 with lit=+5, bcast_cnt=1, quiescent returns to 1.
//  2. proc1 and proc3 non-empty, rr_ptr=0 -> grant order proc1 then proc3; next grant search starts at proc0.
//  3. +7 broadcast, then proc2 implies +7 -> popped, no push, bcast_cnt unchanged, conflict=0.
//  4. +9 broadcast, then proc0 implies -9 -> conflict=1, conflict_lit=-9, no further pops; clear -> conflict=0, +9 re-accepted.
//  5. ucq_out_full[2]=1 for 10 cycles during BCAST -> push deferred exactly until full drops, no pops meanwhile.
//  6. Lit 0 and lit +300 (NUM_VARS=255) -> bad_lit=1, both dropped; rst_n low mid-BCAST -> no push, all outputs 0.

Source files
------------

// File: rtl/uc_bcast_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uc_bcast_arb
//  Description : Unit-clause arbiter. Drains NUM_PROC implication queues
//                round-robin, filters each literal through a global
//                variable-assignment table and broadcasts new literals to
//                every processor. Contradictions latch a sticky conflict.
//  Revision    : 1.0  initial release
// ============================================================================
module uc_bcast_arb #(
    parameter int NUM_PROC = 4,
    parameter int LIT_W    = 16,
    parameter int NUM_VARS = 255,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic [NUM_PROC-1:0]       ucq_in_empty,
    input  logic [NUM_PROC*LIT_W-1:0] ucq_in_lit,
    output logic [NUM_PROC-1:0]       ucq_in_pop,
    input  logic [NUM_PROC-1:0]       ucq_out_full,
    output logic                      ucq_out_push,
    output logic [LIT_W-1:0]          ucq_out_lit,
    output logic                      conflict,
    output logic [LIT_W-1:0]          conflict_lit,
    output logic                      bad_lit,
    output logic                      quiescent,
    output logic [CNT_W-1:0]          bcast_cnt
);

    localparam int PTR_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam int IDX_W = $clog2(NUM_VARS + 1);

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        CHECK = 2'd1,
        BCAST = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [LIT_W-1:0]    cand_q, cand_d;
    logic [NUM_VARS:0]   assigned_q, assigned_d;
    logic [NUM_VARS:0]   value_q, value_d;
    logic                conflict_q, conflict_d;
    logic [LIT_W-1:0]    conflict_lit_q, conflict_lit_d;
    logic                bad_lit_q, bad_lit_d;
    logic [CNT_W-1:0]    bcast_cnt_q, bcast_cnt_d;

    logic [LIT_W-1:0]    lit_arr [NUM_PROC];
    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    probe_idx;
    logic [LIT_W-1:0]    cand_mag;
    logic                cand_in_range;
    logic                cand_pos;
    logic [IDX_W-1:0]    tbl_idx;

    // Unpack the flat head-of-queue bus into one literal per processor
    for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_unpack
        assign lit_arr[gi] = ucq_in_lit[gi*LIT_W +: LIT_W];
    end

    // Round-robin search: first non-empty queue at or after rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        probe_idx   = '0;
        for (int k = 0; k < NUM_PROC; k++) begin
            probe_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_PROC);
            if (!grant_found && !ucq_in_empty[probe_idx]) begin
                grant_found = 1'b1;
                grant_idx   = probe_idx;
            end
        end
    end

    // Decode the latched candidate: magnitude is the variable index, the
    // sign bit is the polarity. The most negative literal has a magnitude
    // beyond any legal index, so it lands in the bad-literal path.
    always_comb begin
        cand_mag      = cand_q[LIT_W-1] ? (~cand_q + LIT_W'(1)) : cand_q;
        cand_in_range = (cand_mag != '0) && (cand_mag <= LIT_W'(NUM_VARS));
        cand_pos      = ~cand_q[LIT_W-1];
        tbl_idx       = cand_mag[IDX_W-1:0];
    end

    // Next-state, table update and handshake outputs
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        cand_d         = cand_q;
        assigned_d     = assigned_q;
        value_d        = value_q;
        conflict_d     = conflict_q;
        conflict_lit_d = conflict_lit_q;
        bad_lit_d      = bad_lit_q;
        bcast_cnt_d    = bcast_cnt_q;
        ucq_in_pop     = '0;
        ucq_out_push   = 1'b0;

        case (state_q)
            SCAN: begin
                if (grant_found) begin
                    ucq_in_pop = NUM_PROC'(1) << grant_idx;
                    cand_d     = lit_arr[grant_idx];
                    rr_ptr_d   = PTR_W'((int'(grant_idx) + 1) % NUM_PROC);
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (!cand_in_range) begin
                    bad_lit_d = 1'b1;
                    state_d   = SCAN;
                end else if (!assigned_q[tbl_idx]) begin
                    assigned_d[tbl_idx] = 1'b1;
                    value_d[tbl_idx]    = cand_pos;
                    state_d             = BCAST;
                end else if (value_q[tbl_idx] == cand_pos) begin
                    state_d = SCAN;
                end else begin
                    conflict_d     = 1'b1;
                    conflict_lit_d = cand_q;
                    state_d        = HALT;
                end
            end
            BCAST: begin
                if (!(|ucq_out_full)) begin
                    ucq_out_push = 1'b1;
                    bcast_cnt_d  = (&bcast_cnt_q) ? bcast_cnt_q
                                                  : bcast_cnt_q + CNT_W'(1);
                    state_d      = SCAN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        // Restart (or reset in progress) suppresses every action this cycle;
        // the round-robin pointer survives a clear so fairness is preserved.
        if (clear || !rst_n) begin
            state_d        = SCAN;
            rr_ptr_d       = rr_ptr_q;
            assigned_d     = '0;
            value_d        = '0;
            conflict_d     = 1'b0;
            conflict_lit_d = '0;
            bad_lit_d      = 1'b0;
            bcast_cnt_d    = '0;
            ucq_in_pop     = '0;
            ucq_out_push   = 1'b0;
        end
    end

    // State and table registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= SCAN;
            rr_ptr_q       <= '0;
            cand_q         <= '0;
            assigned_q     <= '0;
            value_q        <= '0;
            conflict_q     <= 1'b0;
            conflict_lit_q <= '0;
            bad_lit_q      <= 1'b0;
            bcast_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            cand_q         <= cand_d;
            assigned_q     <= assigned_d;
            value_q        <= value_d;
            conflict_q     <= conflict_d;
            conflict_lit_q <= conflict_lit_d;
            bad_lit_q      <= bad_lit_d;
            bcast_cnt_q    <= bcast_cnt_d;
        end
    end

    // Output drive: broadcast literal only qualified by push
    always_comb begin
        ucq_out_lit  = ucq_out_push ? cand_q : '0;
        conflict     = conflict_q;
        conflict_lit = conflict_lit_q;
        bad_lit      = bad_lit_q;
        bcast_cnt    = bcast_cnt_q;
        quiescent    = (state_q == SCAN) && (&ucq_in_empty);
    end

endmodule
`default_nettype wire
